// File: rtl/count_controller.sv
// count_controller: prescaled up-counter sequenced by an IDLE/RUN/HOLD/DONE FSM,
//   with one-shot or auto-reload terminal-count handling and a registered done pulse.
// Ports: clk, rst_n (async, active-low); start/stop/hold controls; cfg_we + cfg_limit,
//   cfg_presc, cfg_reload configuration; count, state, busy, done status outputs.
module count_controller #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               cfg_we,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_reload,
  output logic [WIDTH-1:0]   count,
  output logic [1:0]         state,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  state_t             state_q;
  logic [PRESC_W-1:0] presc_cnt;

  // Programmed configuration, writable only while not sequencing.
  logic [WIDTH-1:0]   limit_q;
  logic [PRESC_W-1:0] presc_q;
  logic               reload_q;

  // Configuration captured at start and used for the whole run. Capturing the
  // programmed registers (not cfg_*) means a write on the same clock as start
  // only lands in the programmed set and applies from the following run.
  logic [WIDTH-1:0]   run_limit;
  logic [PRESC_W-1:0] run_presc;
  logic               run_reload;

  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count      <= '0;
      presc_cnt  <= '0;
      done       <= 1'b0;
      limit_q    <= '1;
      presc_q    <= '0;
      reload_q   <= 1'b0;
      run_limit  <= '1;
      run_presc  <= '0;
      run_reload <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a terminal tick.
        state_q   <= IDLE;
        count     <= '0;
        presc_cnt <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (cfg_we) begin
              limit_q  <= cfg_limit;
              presc_q  <= cfg_presc;
              reload_q <= cfg_reload;
            end
            if (start) begin
              state_q    <= RUN;
              count      <= '0;
              presc_cnt  <= '0;
              run_limit  <= limit_q;
              run_presc  <= presc_q;
              run_reload <= reload_q;
            end
          end
          RUN, HOLD: begin
            if (hold) begin
              state_q <= HOLD;
            end else begin
              // Releasing hold resumes counting on the same clock, so the
              // tick schedule slips by exactly the number of held clocks.
              state_q <= RUN;
              if (presc_cnt == run_presc) begin
                presc_cnt <= '0;
                if (count == run_limit) begin
                  done <= 1'b1;
                  if (run_reload) begin
                    count <= '0;
                  end else begin
                    state_q <= DONE;
                  end
                end else begin
                  count <= count + CNT_ONE;
                end
              end else begin
                presc_cnt <= presc_cnt + PRESC_ONE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_controller.sv
// tb_count_controller: directed stimulus with hand-computed expectations pushed
//   into a scoreboard queue; an independent monitor pops one entry per clock and
//   compares count/state/done/busy one time unit after the rising edge.
module tb_count_controller;

  localparam int WIDTH   = 4;
  localparam int PRESC_W = 8;
  localparam int I = 0, R = 1, H = 2, D = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, hold, cfg_we;
  logic [WIDTH-1:0]   cfg_limit;
  logic [PRESC_W-1:0] cfg_presc;
  logic               cfg_reload;
  logic [WIDTH-1:0]   count;
  logic [1:0]         state;
  logic               busy;
  logic               done;

  count_controller #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .cfg_we     (cfg_we),
    .cfg_limit  (cfg_limit),
    .cfg_presc  (cfg_presc),
    .cfg_reload (cfg_reload),
    .count      (count),
    .state      (state),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    c;
    int    s;
    bit    d;
  } exp_t;

  exp_t  sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    step_no = 0;
  string phase = "reset";

  task automatic compare(input string name, input int ec, input int es, input bit ed);
    logic [WIDTH-1:0] wc;
    logic [1:0]       ws;
    logic             wb;
    wc = WIDTH'(ec);
    ws = 2'(es);
    wb = (es == R) || (es == H);
    vectors++;
    if (count !== wc || state !== ws || done !== ed || busy !== wb) begin
      miscompares++;
      $display("FAIL %s: got count=%0d state=%0d done=%0d busy=%0d, want count=%0d state=%0d done=%0d busy=%0d",
               name, count, state, done, busy, wc, ws, ed, wb);
    end
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e.tag, e.c, e.s, e.d);
      end
    end
  end

  // Queue the expected outputs after the next edge, apply it, drop pulses.
  task automatic st(input int c, input int s, input bit d);
    step_no++;
    sb.push_back('{$sformatf("%s#%0d", phase, step_no), c, s, d});
    @(posedge clk);
    #2;
    start  = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input int lim, input int pr, input bit rl);
    cfg_we     = 1'b1;
    cfg_limit  = WIDTH'(lim);
    cfg_presc  = PRESC_W'(pr);
    cfg_reload = rl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc[10];
    int rc[7];
    oc = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
    rc = '{1, 2, 0, 1, 2, 0, 1};

    rst_n = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; cfg_we = 1'b0;
    cfg_limit = '0; cfg_presc = '0; cfg_reload = 1'b0;
    #1 rst_n = 1'b0;
    #1 compare("reset_immediate", 0, I, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // One-shot: limit 3, presc 1.
    phase = "oneshot";
    cfg(3, 1, 0); st(0, I, 0);
    start = 1'b1; st(0, R, 0);
    for (int i = 0; i < 10; i++) st(oc[i], (i < 7) ? R : D, i == 7);

    // Config write in DONE, auto-reload limit 2 presc 0; write during RUN ignored.
    phase = "reload";
    cfg(2, 0, 1); st(3, D, 0);
    start = 1'b1; st(0, R, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) cfg(9, 0, 0);
      st(rc[i], R, (i == 2) || (i == 5));
    end
    phase = "stop_start";
    start = 1'b1; stop = 1'b1; st(0, I, 0);
    st(0, I, 0);

    // Lockout: limit 9 written mid-run must not extend the run.
    phase = "lockout";
    cfg(2, 0, 0); st(0, I, 0);
    start = 1'b1; st(0, R, 0);
    cfg(9, 0, 0); st(1, R, 0);
    st(2, R, 0);
    st(2, D, 1);
    st(2, D, 0);

    // Write together with start: this run uses limit 2, the next uses limit 1.
    phase = "cfg_with_start";
    cfg(1, 0, 0); start = 1'b1; st(0, R, 0);
    st(1, R, 0);
    st(2, R, 0);
    st(2, D, 1);
    start = 1'b1; st(0, R, 0);
    st(1, R, 0);
    st(1, D, 1);
    st(1, D, 0);

    // Hold for 5 clocks mid-interval with presc 3.
    phase = "hold";
    cfg(5, 3, 0); st(1, D, 0);
    start = 1'b1; st(0, R, 0);
    st(0, R, 0);
    st(0, R, 0);
    hold = 1'b1;
    repeat (5) st(0, H, 0);
    hold = 1'b0;
    st(0, R, 0);
    st(1, R, 0);
    stop = 1'b1; st(0, I, 0);

    // limit 0: stop on the terminal tick gives no done; then done on first tick.
    phase = "limit0";
    cfg(0, 0, 0); st(0, I, 0);
    start = 1'b1; st(0, R, 0);
    stop = 1'b1; st(0, I, 0);
    st(0, I, 0);
    start = 1'b1; st(0, R, 0);
    st(0, D, 1);
    st(0, D, 0);
    phase = "reload_limit0";
    cfg(0, 0, 1); st(0, D, 0);
    start = 1'b1; st(0, R, 0);
    repeat (3) st(0, R, 1);
    stop = 1'b1; st(0, I, 0);

    // Full-width wrap 15 -> 0 in reload mode.
    phase = "wrap15";
    cfg(15, 0, 1); st(0, I, 0);
    start = 1'b1; st(0, R, 0);
    for (int i = 1; i <= 15; i++) st(i, R, 0);
    st(0, R, 1);
    st(1, R, 0);

    // Asynchronous reset between edges while running.
    #2 rst_n = 1'b0;
    #1 compare("reset_midrun", 0, I, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    phase = "post_reset";
    st(0, I, 0);
    st(0, I, 0);
    // Reset config: limit all ones, presc 0, one-shot.
    start = 1'b1; st(0, R, 0);
    for (int i = 1; i <= 15; i++) st(i, R, 0);
    st(15, D, 1);
    st(15, D, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_controller.md
COUNT_CONTROLLER -- requirements
Module: count_controller

Interface
REQ-001 Parameter WIDTH, default 4: width of the sequenced count datapath.
REQ-002 Parameter PRESC_W, default 8: width of the prescaler compare value.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  start request; sampled each clock.
REQ-006 stop  input  1  abort request; sampled each clock.
REQ-007 hold  input  1  level; freezes counting while high.
REQ-008 cfg_we  input  1  configuration write strobe.
REQ-009 cfg_limit  input  WIDTH  terminal count value.
REQ-010 cfg_presc  input  PRESC_W  prescale compare; count advances every cfg_presc+1 cycles.
REQ-011 cfg_reload  input  1  1 = auto-reload mode, 0 = one-shot mode.
REQ-012 count  output  WIDTH  current count value, registered.
REQ-013 state  output  2  FSM state: IDLE=0, RUN=1, HOLD=2, DONE=3.
REQ-014 busy  output  1  high when state is RUN or HOLD; decoded from state only.
REQ-015 done  output  1  registered one-cycle pulse on reaching terminal count.

Function
REQ-016 Config registers (limit, presc, reload) SHALL load from cfg_* on a clock with cfg_we=1 only in IDLE or DONE; cfg_we in RUN/HOLD SHALL be ignored.
REQ-017 start in IDLE or DONE SHALL move to RUN next clock, clearing count and prescaler to 0; start in RUN/HOLD SHALL be ignored.
REQ-018 cfg_we and start in the same IDLE clock: start SHALL use the old config; the new config SHALL apply from the next run.
REQ-019 In RUN with hold=0, the prescaler SHALL increment each clock; when prescaler == presc, a tick SHALL occur: prescaler -> 0.
REQ-020 On a tick with count != limit, count SHALL increment by 1, modulo 2^WIDTH.
REQ-021 On a tick with count == limit and reload=1: count -> 0, done=1 next cycle, state stays RUN.
REQ-022 On a tick with count == limit and reload=0: count holds at limit, done=1 next cycle, state -> DONE.
REQ-023 limit=0 SHALL cause done on the first tick (after presc+1 cycles).
REQ-024 presc=0 SHALL give a tick every RUN clock.
REQ-025 hold=1 in RUN SHALL suppress that clock's tick and prescaler increment and move to HOLD; count and prescaler SHALL freeze.
REQ-026 hold=0 in HOLD SHALL return to RUN next clock, resuming from the frozen prescaler value.
REQ-027 stop SHALL move any state to IDLE next clock, clearing count and prescaler, with no done pulse; stop SHALL take priority over start, hold and terminal tick.
REQ-028 DONE SHALL persist until start or stop; count SHALL hold at limit.
REQ-029 done SHALL never be high for two consecutive cycles, except in reload mode with presc=0 and limit=0, where it SHALL pulse every cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, count=0, prescaler=0, done=0, busy=0, limit=all ones, presc=0, reload=0.
REQ-031 Reset asserted mid-run SHALL abort without a done pulse; after release, the block SHALL idle until start.
REQ-032 The first clock edge after rst_n rises SHALL evaluate inputs normally.

Verification
REQ-033 One-shot: cfg limit=3, presc=1, reload=0; start -> count 0,1,2,3 each changing every 2 clocks; done pulses once; state=DONE; count holds 3.
REQ-034 Auto-reload: limit=2, presc=0, reload=1 -> count 0,1,2,0,1,2...; done high one cycle after each 2->0 wrap; busy stays 1.
REQ-035 Hold: presc=3, assert hold for 5 clocks mid-interval -> count and prescaler frozen; state=HOLD; tick timing shifted exactly 5 clocks after release.
REQ-036 Priority: stop and start together in RUN -> IDLE, count=0. stop on the terminal tick -> no done.
REQ-037 Config lockout: cfg_we with limit=9 during RUN -> ignored, the run terminates at the old limit; a write in DONE takes effect on the next start.
REQ-038 Async reset: drop rst_n mid-RUN between clock edges -> outputs reset immediately; a WIDTH=4, limit=15 wrap run confirms count 15 -> 0 with a done pulse.
